// File: rtl/uart_tx.sv
// uart_tx -- asynchronous serial transmitter, 8-N-1 by default.
//
// A parallel byte is sent as start bit (0), eight data bits LSB first and a
// stop bit (1). Bit timing is built from a 16x oversample tick derived from
// CLOCK_50, so each bit lasts 16 * TICK_DIV clock cycles. This matches the
// receiver's oversampling, so TX looped into RX recovers the byte.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the data bits) follows bit 7,
//                giving an 11-bit frame.
//   undefined -> no parity state or logic; 10-bit frame.
//
// Parameters:
//   TICK_DIV  CLOCK_50 cycles per oversample tick (default 326, ~9585 baud).
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   DataIn    in   byte to send, sampled only when send is accepted
//   send      in   transmit request, accepted in IDLE or at the last edge
//                  of a stop bit (back-to-back frames with no idle gap)
//   TxD       out  serial line, idles high (registered)
//   busy      out  high while a frame is in progress (registered)
//   txDone    out  one-cycle pulse at the end of the stop bit (registered)

module uart_tx #(
    parameter int TICK_DIV = 326
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       send,
    output logic       TxD,
    output logic       busy,
    output logic       txDone
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [DW-1:0] div_q;      // clock cycles within one oversample tick
    logic [3:0]    tcnt_q;     // ticks within one bit
    logic [2:0]    bitcnt_q;   // data bit index 0..7
    logic [7:0]    sh_q, sh_d; // data shift register, bit 0 is on the line
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    logic tick, bit_end, load;
    logic txd_d, busy_d, done_d;

    // Divider only runs while a frame is in flight.
    assign tick    = (state_q != IDLE) && (div_q == DIV_MAX);
    assign bit_end = tick && (tcnt_q == 4'hF);

    // A new byte is taken either from IDLE or exactly at the end of a stop
    // bit, which is what gives zero-gap back-to-back frames.
    assign load = send && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    //------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (send) state_d = START;
            START:  if (bit_end) state_d = DATA;
            DATA:
                if (bit_end && (bitcnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP:   if (bit_end) state_d = send ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Shift register next value (also feeds the registered TxD)
    //------------------------------------------------------------------
    always_comb begin
        sh_d = sh_q;
        if (load)
            sh_d = DataIn;
        else if ((state_q == DATA) && bit_end)
            sh_d = {1'b0, sh_q[7:1]};
    end

    //------------------------------------------------------------------
    // FSM: output logic, evaluated on the next state so the registered
    // outputs change on the same edge as the state.
    //------------------------------------------------------------------
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_end;
        case (state_d)
            IDLE:   txd_d = 1'b1;
            START:  txd_d = 1'b0;
            DATA:   txd_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_d = par_q;
`endif
            STOP:   txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

    //------------------------------------------------------------------
    // Datapath: tick divider, tick counter, bit counter, shift register
    //------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            sh_q     <= '0;
        end else begin
            sh_q <= sh_d;

            if ((state_q == IDLE) || load) begin
                div_q  <= '0;
                tcnt_q <= '0;
            end else if (tick) begin
                div_q  <= '0;
                tcnt_q <= tcnt_q + 4'd1;   // wraps 15->0 at a bit boundary
            end else begin
                div_q  <= div_q + 1'b1;
            end

            // Wraps 7->0 on the last data bit, ready for the next frame.
            if (load)
                bitcnt_q <= '0;
            else if ((state_q == DATA) && bit_end)
                bitcnt_q <= bitcnt_q + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is captured with the byte so later DataIn changes
    // cannot disturb it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            par_q <= 1'b0;
        else if (load)
            par_q <= ^DataIn;
    end
`endif

    //------------------------------------------------------------------
    // Registered outputs
    //------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            TxD    <= 1'b1;
            busy   <= 1'b0;
            txDone <= 1'b0;
        end else begin
            TxD    <= txd_d;
            busy   <= busy_d;
            txDone <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int TD   = 4;
    localparam int BITC = 16 * TD;     // cycles per bit
`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int FRAME = F * BITC;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [7:0] DataIn;
    logic       send;
    logic       TxD, busy, txDone;

    uart_tx #(.TICK_DIV(TD)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .DataIn   (DataIn),
        .send     (send),
        .TxD      (TxD),
        .busy     (busy),
        .txDone   (txDone)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dut_done = 0;

    // Reference model: a frame is an array of line levels, one per bit,
    // indexed by elapsed cycles since acceptance divided by the bit length.
    bit         m_act;
    int         m_cnt;
    logic [7:0] m_byte;
    logic       m_tx, m_busy, m_done;
    int         m_ndone = 0;

    function automatic logic fbit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_cnt = 0; m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_act) begin
                m_cnt++;
                if (m_cnt == FRAME) begin
                    m_act = 0; m_done = 1'b1; m_ndone++;
                end
            end
            if (!m_act && send) begin
                m_act = 1; m_cnt = 0; m_byte = DataIn;
            end
            m_tx   = m_act ? fbit(m_byte, m_cnt / BITC) : 1'b1;
            m_busy = m_act;
        end
    endtask

    // One clock: model follows the rising edge, outputs compared on the
    // falling edge. Inputs are only changed after this returns.
    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        cyc++;
        if (txDone === 1'b1) dut_done++;
        chk("txd",    TxD,    m_tx);
        chk("busy",   busy,   m_busy);
        chk("txdone", txDone, m_done);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send = 1'b1; DataIn = b;
        step();
        send = 1'b0;
    endtask

    int exp_seq[11];
    int d0;

    initial begin
`ifdef UART_TX_PARITY_EN
        exp_seq = '{0,1,0,1,0,0,1,0,1,0,1};
`else
        exp_seq = '{0,1,0,1,0,0,1,0,1,1,1};
`endif
        reset = 1'b1; send = 1'b0; DataIn = 8'h00;
        model_reset();

        // Reset idle
        repeat (3) step();
        reset = 1'b0;
        chk("rst_txd", TxD, 1); chk("rst_busy", busy, 0); chk("rst_done", txDone, 0);
        repeat (1000) step();
        chk("idle_nodone", dut_done, 0);

        // Single byte 0xA5, sampled mid-bit against a literal sequence
        send_byte(8'hA5);
        repeat (32) step();
        chk("a5_bit0", TxD, exp_seq[0]);
        for (int i = 1; i < F; i++) begin
            repeat (BITC) step();
            chk($sformatf("a5_bit%0d", i), TxD, exp_seq[i]);
        end
        repeat (31) step();
        chk("a5_busy_end", busy, 1); chk("a5_nodone_yet", txDone, 0);
        step();
        chk("a5_done", txDone, 1); chk("a5_idle_busy", busy, 0); chk("a5_idle_txd", TxD, 1);
        step();
        chk("a5_done_once", txDone, 0);
        chk("a5_done_cnt", dut_done, 1);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight -> parity bit 1, sampled mid parity bit
        send_byte(8'h07);
        repeat (32 + 9 * BITC) step();
        chk("p07_parity", TxD, 1);
        repeat (FRAME) step();
`endif

        // Ignored send mid-frame
        repeat (5) step();
        d0 = dut_done;
        send_byte(8'h3C);
        repeat (199) step();
        send_byte(8'hFF);
        repeat (FRAME) step();
        chk("ign_done_cnt", dut_done, d0 + 1);

        // Back-to-back: send asserted on the edge the stop bit ends
        d0 = dut_done;
        send_byte(8'h00);
        repeat (FRAME - 1) step();
        send_byte(8'hFF);
        chk("b2b_start", TxD, 0); chk("b2b_busy", busy, 1); chk("b2b_done", txDone, 1);
        repeat (FRAME + 20) step();
        chk("b2b_done_cnt", dut_done, d0 + 2);

        // Mid-frame asynchronous reset
        d0 = dut_done;
        send_byte(8'h81);
        repeat (300) step();
        reset = 1'b1; model_reset();
        #1;
        chk("mrst_txd", TxD, 1); chk("mrst_busy", busy, 0); chk("mrst_done", txDone, 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (FRAME) step();
        chk("mrst_nodone", dut_done, d0);
        send_byte(8'h42);
        repeat (FRAME + 5) step();
        chk("mrst_next_done", dut_done, d0 + 1);

        // Randomized frames with random gaps and ignored sends
        for (int r = 0; r < 25; r++) begin
            int gap, off;
            gap = $urandom_range(0, 15);
            off = $urandom_range(1, FRAME - 2);
            repeat (gap) step();
            send_byte(8'($urandom));
            repeat (off) step();
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
            else step();
            repeat (FRAME) step();
        end

        // send held high: continuous frames, byte re-sampled at each acceptance
        send = 1'b1;
        for (int i = 0; i < 3 * FRAME + 5; i++) begin
            DataIn = 8'($urandom);
            step();
        end
        send = 1'b0;
        repeat (FRAME + 5) step();

        chk("done_total", dut_done, m_ndone);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
